pu_msp430_per_arb: RTL
======================

// Module: pu_msp430_per_arb
// PURPOSE
//  Two-master arbiter directly upstream of the 16-bit peripheral bus (per_addr/per_din/per_en/per_we -> per_dout).
//  Merges CPU (M0) and DMA/debug (M1) requests into one per_* stream for all register-file peripherals.
//  Returns read data, registered, to the granted master one cycle later.
//  Bounded starvation: fixed priority M1>M0, with a counter that forces an M0 win after STARVE_LIM losses.
// PARAMETERS
//  STARVE_LIM  4  consecutive M1 wins over a waiting M0 before M0 is forced through (legal 1..15)
// PORTS
//  mclk          in   1   main system clock
//  puc_rst       in   1   main system reset
//  m0_addr       in   14  M0 word address
//  m0_din        in   16  M0 write data
//  m0_en         in   1   M0 request; held stable until m0_gnt
//  m0_we         in   2   M0 byte write enables (00 = read)
//  m0_gnt        out  1   M0 request accepted this cycle (combinational)
//  m0_dout       out  16  M0 read data, 0 when m0_dout_vld=0
//  m0_dout_vld   out  1   M0 read data valid
//  m1_addr/m1_din/m1_en/m1_we/m1_gnt/m1_dout/m1_dout_vld   same as M0, for master M1
//  per_addr      out  14  peripheral address
//  per_din       out  16  peripheral write data
//  per_en        out  1   peripheral enable
//  per_we        out  2   peripheral write enables
//  per_dout      in   16  OR-combined peripheral read data, valid in the per_en cycle
// BEHAVIOUR
//  Reset: clock and reset are mclk/puc_rst; one clock; reset is asynchronous and active-high.
//  Reset values: all registered outputs 0; starve_cnt=0; rd_pend=0; lock released.
//  Grant (same cycle): g1 = m1_en & ~(m0_en & starve_hit); g0 = m0_en & ~g1; at most one grant per cycle.
//  per_*: muxed from the granted master; per_en = g0|g1; per_addr/per_din/per_we = 0 when no grant.
//  starve_cnt: +1 on each cycle with g1 & m0_en, saturating at STARVE_LIM.
//  starve_cnt clears on g0 or on m0_en=0.
//  starve_hit = (starve_cnt == STARVE_LIM).
//  Read return: a granted read (we==00) in cycle N sets rd_pend and rd_owner.
//  At the cycle-N edge, per_dout is captured into rd_data.
//  In cycle N+1, mX_dout_vld=1 and mX_dout=rd_data for the owner only.
//  The other master sees dout=0 and vld=0.
//  Back-to-back reads from alternating masters are supported: one grant per cycle, one return per cycle, no bubble.
//  Writes produce no dout_vld.
//  Simultaneous M0/M1 requests with starve_hit=0: M1 wins and M0 waits, with its request held.
//  Reset mid-read: the pending return is dropped; no dout_vld after release.
// CONFIGURATION
//  Macro PER_ARB_LOCK_EN adds inputs m0_lock and m1_lock (1 bit each).
//  Lock acquire: a granted request with lock=1 records lock_owner.
//  Lock hold: while lock_owner is set, only that master can be granted and starve_cnt is frozen.
//  Lock release: the owner's first granted access with lock=0.
//  Lock reset: puc_rst also releases the lock.
//  Lock purpose: atomic read-modify-write of peripheral registers.
//  Without the macro: no lock ports or logic; arbitration is exactly as in BEHAVIOUR.
// STRUCTURE
//  Package pu_msp430_per_pkg:
//   owner_t enum {OWN_M0, OWN_M1}
//   PER_AW=14, PER_DW=16
//   STARVE_CW=4
//  Sub-module pu_msp430_per_arb_starve: saturating starve counter; outputs starve_hit.
//  Top: grant logic, per_* mux, read-return register, optional lock register.
// TESTING
//  1. Reset then idle -> per_en=0; m0/m1_dout=0; all vld=0.
//  2. M0 read addr 0x0048 with per_dout=0x00A5 -> m0_gnt same cycle; next cycle m0_dout_vld=1, m0_dout=0x00A5.
//  3. M0 and M1 both request continuously, STARVE_LIM=4 -> grant sequence M1,M1,M1,M1,M0 repeating.
//  4. M1 write we=01 din=0x1234, then M0 read -> per_we=01 for the write; return only to M0; m1_dout_vld never set.
//  5. puc_rst asserted in the cycle after a read grant -> no dout_vld after release; starve_cnt=0.
//  6. PER_ARB_LOCK_EN: M0 read with m0_lock=1 while M1 requests -> M1 blocked until the M0 write with lock=0; then M1 granted next cycle.

Source files
------------

// File: rtl/pu_msp430_per_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pu_msp430_per_pkg
//  Purpose : Shared types and widths for the peripheral-bus arbiter.
//            owner_t identifies which master owns a read return or lock.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pu_msp430_per_pkg;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  localparam int PER_AW    = 14;
  localparam int PER_DW    = 16;
  localparam int STARVE_CW = 4;

endpackage
`default_nettype wire

// File: rtl/pu_msp430_per_arb_starve.sv
`default_nettype none
// ============================================================================
//  Module  : pu_msp430_per_arb_starve
//  Purpose : Saturating count of consecutive M1 wins over a waiting M0.
//            starve_hit tells the grant logic to force M0 through.
//  Ports   : clk, rst      clock / async active-high reset
//            inc           M1 granted while M0 was requesting
//            clr           M0 granted or M0 not requesting
//            freeze        hold the count (bus locked)
//            starve_hit    count has reached STARVE_LIM
//  Rev     : 1.0  initial release
// ============================================================================
module pu_msp430_per_arb_starve
  import pu_msp430_per_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic freeze,
  output logic starve_hit
);

  localparam logic [STARVE_CW-1:0] C_LIM = STARVE_CW'(STARVE_LIM);

  logic [STARVE_CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!freeze) begin
      if (clr) begin
        r_cnt <= '0;
      end else if (inc && (r_cnt != C_LIM)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign starve_hit = (r_cnt == C_LIM);

endmodule
`default_nettype wire

// File: rtl/pu_msp430_per_arb.sv
`default_nettype none
// ============================================================================
//  Module  : pu_msp430_per_arb
//  Purpose : Two-master arbiter in front of the 16-bit peripheral bus.
//            Fixed priority M1 > M0 with bounded M0 starvation; read data
//            is registered and returned to the granting master next cycle.
//            Optional bus lock (macro PER_ARB_LOCK_EN) for atomic RMW.
//  Ports   : mclk, puc_rst                 clock / async active-high reset
//            mX_addr/din/en/we (X=0,1)     master requests
//            mX_lock                       lock request (PER_ARB_LOCK_EN only)
//            mX_gnt                        same-cycle grant
//            mX_dout/mX_dout_vld           read return, one cycle after grant
//            per_addr/din/en/we, per_dout  peripheral bus
//  Rev     : 1.0  initial release
// ============================================================================
module pu_msp430_per_arb
  import pu_msp430_per_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic [PER_AW-1:0] m0_addr,
  input  logic [PER_DW-1:0] m0_din,
  input  logic              m0_en,
  input  logic [1:0]        m0_we,
`ifdef PER_ARB_LOCK_EN
  input  logic              m0_lock,
`endif
  output logic              m0_gnt,
  output logic [PER_DW-1:0] m0_dout,
  output logic              m0_dout_vld,
  input  logic [PER_AW-1:0] m1_addr,
  input  logic [PER_DW-1:0] m1_din,
  input  logic              m1_en,
  input  logic [1:0]        m1_we,
`ifdef PER_ARB_LOCK_EN
  input  logic              m1_lock,
`endif
  output logic              m1_gnt,
  output logic [PER_DW-1:0] m1_dout,
  output logic              m1_dout_vld,
  output logic [PER_AW-1:0] per_addr,
  output logic [PER_DW-1:0] per_din,
  output logic              per_en,
  output logic [1:0]        per_we,
  input  logic [PER_DW-1:0] per_dout
);

  logic              w_g0;
  logic              w_g1;
  logic              w_starve_hit;
  logic              w_lock_m0;
  logic              w_lock_m1;
  logic              w_freeze;
  logic              w_rd_gnt;

  logic              r_rd_pend;
  owner_t            r_rd_owner;
  logic [PER_DW-1:0] r_rd_data;

  // --------------------------------------------------------------------------
  // Optional lock: the owner keeps the bus until it issues an access with
  // lock=0. Only the owner can be granted, so release needs no owner compare.
  // --------------------------------------------------------------------------
`ifdef PER_ARB_LOCK_EN
  logic   r_lock_vld;
  owner_t r_lock_own;
  logic   w_gnt_lock;

  assign w_gnt_lock = w_g1 ? m1_lock : m0_lock;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_lock_vld <= 1'b0;
      r_lock_own <= OWN_M0;
    end else if (w_g0 || w_g1) begin
      if (!r_lock_vld && w_gnt_lock) begin
        r_lock_vld <= 1'b1;
        r_lock_own <= w_g1 ? OWN_M1 : OWN_M0;
      end else if (r_lock_vld && !w_gnt_lock) begin
        r_lock_vld <= 1'b0;
      end
    end
  end

  assign w_lock_m0 = r_lock_vld && (r_lock_own == OWN_M0);
  assign w_lock_m1 = r_lock_vld && (r_lock_own == OWN_M1);
  assign w_freeze  = r_lock_vld;
`else
  assign w_lock_m0 = 1'b0;
  assign w_lock_m1 = 1'b0;
  assign w_freeze  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant. Without a lock this reduces to
  //   g1 = m1_en & ~(m0_en & starve_hit); g0 = m0_en & ~g1.
  // A lock held by M1 overrides starvation so M0 cannot break an RMW.
  // --------------------------------------------------------------------------
  assign w_g1 = m1_en && !w_lock_m0 && (w_lock_m1 || !(m0_en && w_starve_hit));
  assign w_g0 = m0_en && !w_g1 && !w_lock_m1;

  assign m0_gnt = w_g0;
  assign m1_gnt = w_g1;

  pu_msp430_per_arb_starve #(
    .STARVE_LIM (STARVE_LIM)
  ) u_starve (
    .clk        (mclk),
    .rst        (puc_rst),
    .inc        (w_g1 && m0_en),
    .clr        (w_g0 || !m0_en),
    .freeze     (w_freeze),
    .starve_hit (w_starve_hit)
  );

  // --------------------------------------------------------------------------
  // Peripheral bus mux; all fields zero when nothing is granted.
  // --------------------------------------------------------------------------
  always_comb begin
    per_addr = '0;
    per_din  = '0;
    per_we   = 2'b00;
    if (w_g1) begin
      per_addr = m1_addr;
      per_din  = m1_din;
      per_we   = m1_we;
    end else if (w_g0) begin
      per_addr = m0_addr;
      per_din  = m0_din;
      per_we   = m0_we;
    end
  end

  assign per_en = w_g0 || w_g1;

  // --------------------------------------------------------------------------
  // Read return. per_dout is valid in the grant cycle and captured at its
  // closing edge; a new read can be captured every cycle with no bubble.
  // --------------------------------------------------------------------------
  assign w_rd_gnt = per_en && (per_we == 2'b00);

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_M0;
      r_rd_data  <= '0;
    end else begin
      r_rd_pend <= w_rd_gnt;
      if (w_rd_gnt) begin
        r_rd_owner <= w_g1 ? OWN_M1 : OWN_M0;
        r_rd_data  <= per_dout;
      end
    end
  end

  assign m0_dout_vld = r_rd_pend && (r_rd_owner == OWN_M0);
  assign m1_dout_vld = r_rd_pend && (r_rd_owner == OWN_M1);
  assign m0_dout     = m0_dout_vld ? r_rd_data : '0;
  assign m1_dout     = m1_dout_vld ? r_rd_data : '0;

endmodule
`default_nettype wire
